// File: rtl/xor_mpram_pkg.sv
// Shared types for the XOR-encoded multiport RAM: clear FSM states and the
// write-pipeline stage-1 entry. Entry fields are sized for the default build.
package xor_mpram_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int XM_WIDTH  = 8;
    localparam int XM_DEPTH  = 256;
    localparam int XM_WPORTS = 2;
    localparam int XM_RPORTS = 2;
    localparam int XM_AW     = addr_w(XM_DEPTH);
    localparam int XM_PW     = (XM_WPORTS > 1) ? $clog2(XM_WPORTS) : 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                vld;
        logic [XM_PW-1:0]    port;
        logic [XM_AW-1:0]    addr;
        logic [XM_WIDTH-1:0] enc;
    } s1_ent_t;

endpackage

// File: rtl/xor_bank_ram.sv
// 1W1R storage bank, registered read returning the old word on same-address write.
// Latency 1 on reads; no backpressure, no reset on storage.
module xor_bank_ram
    import xor_mpram_pkg::*;
#(
    parameter int WIDTH = XM_WIDTH,
    parameter int AW    = XM_AW
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [2**AW];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/xor_mpram.sv
// XOR-encoded multi-write/multi-read RAM over 1W1R banks; optional XOR_MPRAM_BYPASS_EN.
// Latency: read 1 cycle, write visible 2 cycles after acceptance (0 with bypass).
// No backpressure: requests ignored while ready=0, colliding writes dropped (wr_drop).
module xor_mpram
    import xor_mpram_pkg::*;
#(
    parameter int WIDTH  = XM_WIDTH,
    parameter int DEPTH  = XM_DEPTH,
    parameter int WPORTS = XM_WPORTS,
    parameter int RPORTS = XM_RPORTS,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         ready,
    input  logic [WPORTS-1:0]            wr_en,
    input  logic [WPORTS-1:0][AW-1:0]    wr_addr,
    input  logic [WPORTS-1:0][WIDTH-1:0] wr_data,
    input  logic [RPORTS-1:0]            rd_en,
    input  logic [RPORTS-1:0][AW-1:0]    rd_addr,
    output logic [RPORTS-1:0][WIDTH-1:0] rd_data,
    output logic [RPORTS-1:0]            rd_valid,
    output logic [WPORTS-1:0]            wr_drop
);

    localparam int NREP = RPORTS + WPORTS - 1;
    localparam int NOTH = (WPORTS > 1) ? WPORTS - 1 : 1;

    // k-th "other" write port as seen from port u
    function automatic int oth(input int u, input int k);
        return (k < u) ? k : k + 1;
    endfunction

    // replica of bank v that serves the S0 read of write port u
    function automatic int rep_of(input int u, input int v);
        return RPORTS + ((u < v) ? u : u - 1);
    endfunction

    state_t                             r_state, w_state_nxt;
    logic [AW-1:0]                      r_clr_addr;
    logic                               w_clr;

    logic [WPORTS-1:0]                  w_acc, w_lost;
    logic [WPORTS-1:0]                  r_s1_vld;
    logic [WPORTS-1:0][AW-1:0]          r_s1_addr;
    logic [WPORTS-1:0][WIDTH-1:0]       r_s1_dat;
    logic [WPORTS-1:0][NOTH-1:0]        r_fwd_hit, w_fwd_hit;
    logic [WPORTS-1:0][NOTH-1:0][WIDTH-1:0] r_fwd_val, w_fwd_val;
    logic [WPORTS-1:0][WIDTH-1:0]       w_enc;
    s1_ent_t                            w_s1 [WPORTS];

    logic [WPORTS-1:0]                  w_bank_we;
    logic [WPORTS-1:0][AW-1:0]          w_bank_waddr;
    logic [WPORTS-1:0][WIDTH-1:0]       w_bank_wdata;
    logic [WIDTH-1:0]                   w_rep_q [WPORTS][NREP];

    logic [RPORTS-1:0]                  r_rd_vld;
    logic [RPORTS-1:0][WIDTH-1:0]       w_rd_x;
    logic [WPORTS-1:0]                  r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (r_clr_addr == AW'(DEPTH - 1)) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_comb begin
        ready = (r_state == RUN);
        w_clr = (r_state == INIT);
    end

    // Same-cycle same-address writes: lowest index keeps the slot
    always_comb begin
        w_acc  = '0;
        w_lost = '0;
        for (int w = 0; w < WPORTS; w++) begin
            w_acc[w] = ready & wr_en[w];
            for (int p = 0; p < WPORTS; p++) begin
                if (p < w && ready && wr_en[p] && wr_addr[p] == wr_addr[w]) begin
                    w_acc[w] = 1'b0;
                end
            end
            w_lost[w] = ready & wr_en[w] & ~w_acc[w];
        end
    end

    always_comb begin
        w_enc = '0;
        for (int u = 0; u < WPORTS; u++) begin
            w_enc[u] = r_s1_dat[u];
            for (int k = 0; k < WPORTS - 1; k++) begin
                if (r_fwd_hit[u][k]) begin
                    w_enc[u] = w_enc[u] ^ r_fwd_val[u][k];
                end else begin
                    w_enc[u] = w_enc[u] ^ w_rep_q[oth(u, k)][rep_of(u, oth(u, k))];
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < WPORTS; e++) begin
            w_s1[e] = '{vld: r_s1_vld[e], port: XM_PW'(e), addr: r_s1_addr[e], enc: w_enc[e]};
        end
    end

    // An S0 read of a bank that is being written this cycle at the same address
    // would return the stale word; take the in-flight encoded value instead.
    always_comb begin
        w_fwd_hit = '0;
        w_fwd_val = '0;
        for (int u = 0; u < WPORTS; u++) begin
            for (int k = 0; k < WPORTS - 1; k++) begin
                for (int e = 0; e < WPORTS; e++) begin
                    if (w_s1[e].vld && w_s1[e].port == XM_PW'(oth(u, k)) &&
                        w_s1[e].addr == wr_addr[u]) begin
                        w_fwd_hit[u][k] = 1'b1;
                        w_fwd_val[u][k] = w_s1[e].enc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= '0;
            r_s1_addr <= '0;
            r_s1_dat  <= '0;
            r_fwd_hit <= '0;
            r_fwd_val <= '0;
            r_drop    <= '0;
            r_rd_vld  <= '0;
        end else begin
            r_s1_vld  <= w_acc;
            r_s1_addr <= wr_addr;
            r_s1_dat  <= wr_data;
            r_fwd_hit <= w_fwd_hit;
            r_fwd_val <= w_fwd_val;
            r_drop    <= w_lost;
            r_rd_vld  <= rd_en & {RPORTS{ready}};
        end
    end

    always_comb begin
        for (int w = 0; w < WPORTS; w++) begin
            w_bank_we[w]    = w_clr | r_s1_vld[w];
            w_bank_waddr[w] = w_clr ? r_clr_addr : r_s1_addr[w];
            w_bank_wdata[w] = w_clr ? '0 : w_enc[w];
        end
    end

    for (genvar gw = 0; gw < WPORTS; gw++) begin : g_bank
        for (genvar gj = 0; gj < NREP; gj++) begin : g_rep
            logic [AW-1:0] w_raddr;
            if (gj < RPORTS) begin : g_rd
                assign w_raddr = rd_addr[gj];
            end else begin : g_wr
                assign w_raddr = wr_addr[oth(gw, gj - RPORTS)];
            end
            xor_bank_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
                .clk     (clk),
                .i_we    (w_bank_we[gw]),
                .i_waddr (w_bank_waddr[gw]),
                .i_wdata (w_bank_wdata[gw]),
                .i_raddr (w_raddr),
                .o_rdata (w_rep_q[gw][gj])
            );
        end
    end

`ifdef XOR_MPRAM_BYPASS_EN
    logic [RPORTS-1:0]            r_byp_hit, w_byp_hit;
    logic [RPORTS-1:0][WIDTH-1:0] r_byp_dat, w_byp_dat;

    // S1 entries are older than S0 winners; the descending loop leaves port 0 on top
    always_comb begin
        w_byp_hit = '0;
        w_byp_dat = '0;
        for (int r = 0; r < RPORTS; r++) begin
            for (int e = 0; e < WPORTS; e++) begin
                if (w_s1[e].vld && w_s1[e].addr == rd_addr[r]) begin
                    w_byp_hit[r] = 1'b1;
                    w_byp_dat[r] = r_s1_dat[e];
                end
            end
            for (int w = WPORTS - 1; w >= 0; w--) begin
                if (w_acc[w] && wr_addr[w] == rd_addr[r]) begin
                    w_byp_hit[r] = 1'b1;
                    w_byp_dat[r] = wr_data[w];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_hit <= '0;
            r_byp_dat <= '0;
        end else begin
            r_byp_hit <= w_byp_hit;
            r_byp_dat <= w_byp_dat;
        end
    end
`endif

    always_comb begin
        w_rd_x  = '0;
        rd_data = '0;
        for (int r = 0; r < RPORTS; r++) begin
            for (int w = 0; w < WPORTS; w++) begin
                w_rd_x[r] = w_rd_x[r] ^ w_rep_q[w][r];
            end
`ifdef XOR_MPRAM_BYPASS_EN
            if (r_byp_hit[r]) begin
                w_rd_x[r] = r_byp_dat[r];
            end
`endif
            rd_data[r] = r_rd_vld[r] ? w_rd_x[r] : '0;
        end
    end

    assign rd_valid = r_rd_vld;
    assign wr_drop  = r_drop;

endmodule

// File: tb/tb_xor_mpram.sv
// Self-checking bench for xor_mpram: read scoreboard, write/read vector table,
// hand-written sequences for forwarding, collisions, read-during-write and reset.
module tb_xor_mpram;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ready;
    logic [1:0]      wr_en = '0;
    logic [1:0][7:0] wr_addr = '0;
    logic [1:0][7:0] wr_data = '0;
    logic [1:0]      rd_en = '0;
    logic [1:0][7:0] rd_addr = '0;
    logic [1:0][7:0] rd_data;
    logic [1:0]      rd_valid;
    logic [1:0]      wr_drop;

    xor_mpram #(.WIDTH(8), .DEPTH(256), .WPORTS(2), .RPORTS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [7:0] exp;
        int         id;
    } exp_t;

    typedef struct {
        int         wp;
        logic [7:0] wa;
        logic [7:0] wd;
        int         rp;
        logic [7:0] ra;
        logic [7:0] exp;
    } vec_t;

    exp_t       sbq[$];
    vec_t       tv[8];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_drop = '0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (id %0d): got %0h, expected %0h", nm, id, act, req);
        end
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic wr(input int p, input logic [7:0] a, input logic [7:0] d);
        wr_en[p]   = 1'b1;
        wr_addr[p] = a;
        wr_data[p] = d;
    endtask

    task automatic rd(input int p, input logic [7:0] a, input logic [7:0] e, input int id);
        exp_t x;
        rd_en[p]   = 1'b1;
        rd_addr[p] = a;
        x.port = p;
        x.exp  = e;
        x.id   = id;
        sbq.push_back(x);
    endtask

    // Advance to the next falling edge, check outputs of the last rising edge, then idle inputs
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (rd_valid[r]) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: port %0d rd_valid=1, no read outstanding (data %0h)", r, rd_data[r]);
                end else begin
                    e = sbq.pop_front();
                    chk("rd_port", e.id, r, e.port);
                    chk("rd_data", e.id, rd_data[r], e.exp);
                end
            end
        end
        chk("wr_drop", 0, wr_drop, exp_drop);
        exp_drop = '0;
        idle();
    endtask

    // Counts cycles with ready=0 while hammering requests that must be ignored
    task automatic wait_ready(output int cnt);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ready) break;
            cnt++;
            wr(0, 8'h03, 8'hEE);
            wr(1, 8'h03, 8'h11);
            rd_en      = 2'b11;
            rd_addr[0] = 8'h03;
            rd_addr[1] = 8'h10;
            tick();
        end
    endtask

    initial begin
        int         cnt;
        logic [7:0] old9;
        logic [7:0] rdw_exp;

        tv[0] = '{wp: 0, wa: 8'h10, wd: 8'hA5, rp: 0, ra: 8'h10, exp: 8'hA5};
        tv[1] = '{wp: 1, wa: 8'h10, wd: 8'h3C, rp: 1, ra: 8'h10, exp: 8'h3C};
        tv[2] = '{wp: 1, wa: 8'h20, wd: 8'h5A, rp: 0, ra: 8'h20, exp: 8'h5A};
        tv[3] = '{wp: 0, wa: 8'hFF, wd: 8'h01, rp: 1, ra: 8'hFF, exp: 8'h01};
        tv[4] = '{wp: 0, wa: 8'h00, wd: 8'h80, rp: 0, ra: 8'h00, exp: 8'h80};
        tv[5] = '{wp: 1, wa: 8'hFF, wd: 8'hC3, rp: 0, ra: 8'hFF, exp: 8'hC3};
        tv[6] = '{wp: 0, wa: 8'h10, wd: 8'h0F, rp: 1, ra: 8'h10, exp: 8'h0F};
        tv[7] = '{wp: 1, wa: 8'h40, wd: 8'h99, rp: 1, ra: 8'h20, exp: 8'h5A};

        // Reset values
        #12;
        chk("rst_ready", 0, ready, 0);
        chk("rst_rd_valid", 0, rd_valid, 0);
        chk("rst_rd_data", 0, rd_data, 0);
        chk("rst_wr_drop", 0, wr_drop, 0);
        tick();
        rst_n = 1'b1;

        // Clear lasts exactly DEPTH cycles, then every word reads 0
        wait_ready(cnt);
        chk("init_len", 0, cnt, 256);
        for (int a = 0; a < 256; a++) begin
            rd(0, 8'(a), 8'h00, 1000 + a);
            rd(1, 8'(255 - a), 8'h00, 2000 + a);
            tick();
        end
        tick();

        // Vector table: write, gap, read two cycles later
        for (int i = 0; i < 8; i++) begin
            wr(tv[i].wp, tv[i].wa, tv[i].wd);
            tick();
            tick();
            rd(tv[i].rp, tv[i].ra, tv[i].exp, 100 + i);
            tick();
        end
        tick();

        // Back-to-back writes from different ports to one address need forwarding
        wr(0, 8'h05, 8'h11);
        tick();
        wr(1, 8'h05, 8'h22);
        tick();
        tick();
        rd(0, 8'h05, 8'h22, 300);
        rd(1, 8'h05, 8'h22, 301);
        tick();
        wr(1, 8'h05, 8'h44);
        tick();
        wr(0, 8'h05, 8'h66);
        tick();
        tick();
        rd(1, 8'h05, 8'h66, 302);
        tick();

        // Same-address collision drops port 1; different addresses both land
        wr(0, 8'h07, 8'h55);
        wr(1, 8'h07, 8'hAA);
        exp_drop = 2'b10;
        tick();
        wr(0, 8'h08, 8'h12);
        wr(1, 8'h18, 8'h34);
        tick();
        tick();
        rd(0, 8'h07, 8'h55, 400);
        rd(1, 8'h08, 8'h12, 401);
        tick();
        rd(0, 8'h18, 8'h34, 402);
        tick();

        // Read during write
        old9 = 8'h42;
        wr(0, 8'h09, old9);
        tick();
        tick();
`ifdef XOR_MPRAM_BYPASS_EN
        rdw_exp = 8'h77;
`else
        rdw_exp = old9;
`endif
        wr(0, 8'h09, 8'h77);
        rd(0, 8'h09, rdw_exp, 500);
        rd(1, 8'h20, 8'h5A, 501);
        tick();
        rd(1, 8'h09, rdw_exp, 502);
        tick();
        rd(0, 8'h09, 8'h77, 503);
        tick();
        tick();

        // Reset mid-traffic restarts the clear
        wr(0, 8'h03, 8'hFF);
        tick();
        tick();
        rd(0, 8'h03, 8'hFF, 600);
        tick();
        tick();
        wr(1, 8'h03, 8'h12);
        wr(0, 8'h50, 8'h66);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 0, ready, 0);
        chk("mid_rst_rd_valid", 0, rd_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(cnt);
        chk("reinit_len", 0, cnt, 256);
        rd(0, 8'h03, 8'h00, 601);
        rd(1, 8'h50, 8'h00, 602);
        tick();
        rd(0, 8'h10, 8'h00, 603);
        rd(1, 8'hFF, 8'h00, 604);
        tick();

        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
            tick();
        end
        chk("drain", 0, sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
